group_snapshot_arbiter: RTL and testbench

Group-fair 2-D arbiter for one level of the pixel hierarchy. At the start of each group it captures a snapshot of the `Lvl_ROWS x Lvl_COLS` request matrix. It then grants every snapshotted request exactly once, in row-major round-robin order, and pulses `grp_release_o` when the group is exhausted. Requests that arrive mid-group wait for the next snapshot. It sits beside the per-level row/column arbiters and is clocked by the level's group-release clock, so it can directly replace the separate row and column round-robin pair.

---
 rtl/lib_arbiter_pkg.sv | 16 +
 rtl/group_snapshot_arbiter_if.sv | 34 +++
 rtl/raster_rr_pick.sv | 39 +++
 rtl/group_snapshot_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_group_snapshot_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lib_arbiter_pkg.sv
// Shared parameters and types for the per-level pixel-hierarchy arbiters.
package lib_arbiter_pkg;

  localparam int Lvl_ROWS = 4;
  localparam int Lvl_COLS = 4;
  localparam int Lvl_ADD  = $clog2((Lvl_ROWS > Lvl_COLS) ? Lvl_ROWS : Lvl_COLS);
  localparam int CNT_W    = $clog2(Lvl_ROWS * Lvl_COLS + 1);

  // Group arbiter phases: wait for a snapshot, drain it, signal the group end.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } gsa_state_t;

endpackage

// File: rtl/group_snapshot_arbiter_if.sv
// Request/grant bundle between a level's request matrix and its group arbiter.
interface group_snapshot_arbiter_if
  import lib_arbiter_pkg::*;
#(
  parameter int ROWS = Lvl_ROWS,
  parameter int COLS = Lvl_COLS,
  parameter int ADD  = Lvl_ADD,
  parameter int CW   = CNT_W
);

  logic                       enable_i;
  logic                       refresh_i;
  logic [ROWS-1:0][COLS-1:0]  req_i;
  logic [ROWS-1:0][COLS-1:0]  gnt_o;
  logic [ADD-1:0]             x_add_o;
  logic [ADD-1:0]             y_add_o;
  logic                       valid_o;
  logic [CW-1:0]              pending_cnt_o;
  logic                       grp_release_o;
  logic                       req_o;

  // Arbiter side.
  modport slave (
    input  enable_i, refresh_i, req_i,
    output gnt_o, x_add_o, y_add_o, valid_o, pending_cnt_o, grp_release_o, req_o
  );

  // Requester / higher-level side.
  modport master (
    output enable_i, refresh_i, req_i,
    input  gnt_o, x_add_o, y_add_o, valid_o, pending_cnt_o, grp_release_o, req_o
  );

endinterface

// File: rtl/raster_rr_pick.sv
// Round-robin picker over a row-major flattened matrix: first set bit strictly
// after ptr, wrapping. The vector is doubled so the wrap becomes a plain
// lowest-set-bit search inside a window of N positions.
module raster_rr_pick #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     snap_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N-1:0] dbl_s;
  logic [2*N-1:0] win_s;
  logic [2*N-1:0] masked_s;

  assign dbl_s    = {snap_i, snap_i};
  assign masked_s = dbl_s & win_s;

  // Window selects doubled positions ptr+1 .. ptr+N, i.e. one full lap.
  always_comb begin
    win_s = '0;
    for (int p = 0; p < 2 * N; p++) begin
      win_s[p] = (p > int'(ptr_i)) && (p <= int'(ptr_i) + N);
    end
  end

  // Lowest set bit in the window, folded back into 0..N-1.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int p = 2 * N - 1; p >= 0; p--) begin
      found_o = found_o | masked_s[p];
      idx_o   = masked_s[p] ? ((p >= N) ? IDX_W'(p - N) : IDX_W'(p)) : idx_o;
    end
  end

endmodule

// File: rtl/group_snapshot_arbiter.sv
// Group-fair 2-D arbiter: snapshot the request matrix, grant each captured
// request once in row-major round-robin order, then pulse grp_release_o.
module group_snapshot_arbiter
  import lib_arbiter_pkg::*;
#(
  parameter int Lvl_ROWS = lib_arbiter_pkg::Lvl_ROWS,
  parameter int Lvl_COLS = lib_arbiter_pkg::Lvl_COLS,
  parameter int Lvl_ADD  = lib_arbiter_pkg::Lvl_ADD,
  parameter int CNT_W    = $clog2(Lvl_ROWS * Lvl_COLS + 1)
) (
  input  logic                    grp_release_clk,
  input  logic                    reset_i,
  group_snapshot_arbiter_if.slave arb_if
);

  localparam int N     = Lvl_ROWS * Lvl_COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     OH_BASE  = {{(N-1){1'b0}}, 1'b1};

  gsa_state_t         state_q, state_d;
  logic [N-1:0]       snap_q, snap_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [Lvl_ADD-1:0] x_q, x_d, y_q, y_d;
  logic               valid_q, valid_d;
  logic               rel_q, rel_d;

  logic [N-1:0]       req_s;
  logic               req_any_s;
  logic               found_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [N-1:0]       pick_oh_s;
  logic               grant_fire_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign req_s        = arb_if.req_i;
  assign req_any_s    = |req_s;
  assign pick_oh_s    = OH_BASE << pick_idx_s;
  assign grant_fire_s = arb_if.enable_i && (state_q == GRANT) && found_s;

  raster_rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .snap_i  (snap_q),
    .ptr_i   (ptr_q),
    .found_o (found_s),
    .idx_o   (pick_idx_s)
  );

  // Pointer: refresh wins over the grant update; otherwise track the last grant.
  always_comb begin
    if (arb_if.refresh_i) begin
      ptr_d = PTR_LAST;
    end else if (grant_fire_s) begin
      ptr_d = pick_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Next-state and registered-output logic of the group FSM.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    gnt_d     = gnt_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = valid_q;
    rel_d     = rel_q;
    if (!arb_if.enable_i) begin
      state_d   = IDLE;
      snap_d    = '0;
      pending_d = '0;
      gnt_d     = '0;
      valid_d   = 1'b0;
      rel_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_d   = '0;
          valid_d = 1'b0;
          rel_d   = 1'b0;
          if (req_any_s) begin
            snap_d    = req_s;
            pending_d = popcount(req_s);
            state_d   = GRANT;
          end else begin
            state_d   = IDLE;
          end
        end
        GRANT: begin
          rel_d = 1'b0;
          if (found_s) begin
            gnt_d     = pick_oh_s;
            x_d       = Lvl_ADD'(int'(pick_idx_s) / Lvl_COLS);
            y_d       = Lvl_ADD'(int'(pick_idx_s) % Lvl_COLS);
            valid_d   = 1'b1;
            snap_d    = snap_q & ~pick_oh_s;
            pending_d = pending_q - CNT_ONE;
            if (pending_q == CNT_ONE) begin
              state_d = RELEASE;
            end else begin
              state_d = GRANT;
            end
          end else begin
            // Empty snapshot here means corrupted state: recover to IDLE.
            state_d   = IDLE;
            snap_d    = '0;
            pending_d = '0;
            gnt_d     = '0;
            valid_d   = 1'b0;
          end
        end
        RELEASE: begin
          gnt_d   = '0;
          valid_d = 1'b0;
          if (!rel_q) begin
            // First edge: raise the one-cycle release pulse.
            rel_d   = 1'b1;
            state_d = RELEASE;
          end else begin
            // Second edge: drop the pulse and start the next group directly.
            rel_d = 1'b0;
            if (req_any_s) begin
              snap_d    = req_s;
              pending_d = popcount(req_s);
              state_d   = GRANT;
            end else begin
              snap_d    = '0;
              pending_d = '0;
              state_d   = IDLE;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          snap_d    = '0;
          pending_d = '0;
          gnt_d     = '0;
          valid_d   = 1'b0;
          rel_d     = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any group immediately.
  always_ff @(posedge grp_release_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      ptr_q     <= PTR_LAST;
      pending_q <= '0;
      gnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      gnt_q     <= gnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      rel_q     <= rel_d;
    end
  end

  assign arb_if.gnt_o         = gnt_q;
  assign arb_if.x_add_o       = x_q;
  assign arb_if.y_add_o       = y_q;
  assign arb_if.valid_o       = valid_q;
  assign arb_if.pending_cnt_o = pending_q;
  assign arb_if.grp_release_o = rel_q;
  assign arb_if.req_o         = req_any_s;

endmodule

// File: tb/tb_group_snapshot_arbiter.sv
// Self-checking bench for group_snapshot_arbiter (4x4) with a grant-order model.
module tb_group_snapshot_arbiter;
  import lib_arbiter_pkg::*;

  logic grp_release_clk = 1'b0;
  logic reset_i;

  group_snapshot_arbiter_if arb_if ();

  group_snapshot_arbiter dut (
    .grp_release_clk (grp_release_clk),
    .reset_i         (reset_i),
    .arb_if          (arb_if)
  );

  always #5 grp_release_clk = ~grp_release_clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 15;     // model: index of last grant
  int lx = 0;         // model: last granted row
  int ly = 0;         // model: last granted column
  int exp_q[$];       // model: expected grant order of the current group

  // Grant order = snapshot indices ordered by distance after the pointer.
  function automatic void build_order(input logic [15:0] bits);
    exp_q.delete();
    for (int k = 1; k <= 16; k++) begin
      int i;
      i = (m_ptr + k) % 16;
      if (bits[i]) exp_q.push_back(i);
    end
  endfunction

  function automatic logic [15:0] oh(input int i);
    logic [15:0] b;
    b = 16'd1;
    return b << i;
  endfunction

  function automatic logic [26:0] expv(input logic [15:0] g, input logic v, input int p,
                                       input logic r, input int x, input int y);
    return {g, v, 5'(p), r, 2'(x), 2'(y)};
  endfunction

  function automatic logic [26:0] obs();
    logic [15:0] g;
    g = arb_if.gnt_o;
    return {g, arb_if.valid_o, arb_if.pending_cnt_o, arb_if.grp_release_o,
            arb_if.x_add_o, arb_if.y_add_o};
  endfunction

  task automatic step();
    @(posedge grp_release_clk);
    #1;
  endtask

  task automatic do_refresh();
    arb_if.refresh_i = 1'b1;
    step();
    arb_if.refresh_i = 1'b0;
    m_ptr = 15;
  endtask

  task automatic test_reset();
    logic [26:0] e;
    step(); step();
    e = expv(16'd0, 1'b0, 0, 1'b0, 0, 0); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_values: got %h expected %h", obs(), e); end
    reset_i = 1'b0; arb_if.enable_i = 1'b1; arb_if.req_i = 16'hFFFF;
    step(); arb_if.req_i = '0;
    step(); step(); step();
    e = expv(oh(2), 1'b1, 13, 1'b0, 0, 2); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_pre_grant: got %h expected %h", obs(), e); end
    #2 reset_i = 1'b1;
    #1;
    e = expv(16'd0, 1'b0, 0, 1'b0, 0, 0); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_async: got %h expected %h", obs(), e); end
    step(); reset_i = 1'b0; m_ptr = 15; lx = 0; ly = 0;
    arb_if.req_i = oh(1) | oh(3);
    step(); arb_if.req_i = '0;
    build_order(oh(1) | oh(3));
    for (int k = 0; k < exp_q.size(); k++) begin
      step();
      m_ptr = exp_q[k]; lx = m_ptr / 4; ly = m_ptr % 4;
      e = expv(oh(m_ptr), 1'b1, exp_q.size() - 1 - k, 1'b0, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL reset_ptr_grant: got %h expected %h", obs(), e); end
    end
    step(); step();
  endtask

  task automatic test_basic_group();
    logic [26:0] e;
    logic [15:0] bits;
    do_refresh();
    bits = oh(1) | oh(11) | oh(12);
    arb_if.req_i = bits;
    step(); arb_if.req_i = '0;
    e = expv(16'd0, 1'b0, 3, 1'b0, lx, ly); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL basic_snapshot: got %h expected %h", obs(), e); end
    build_order(bits);
    for (int k = 0; k < exp_q.size(); k++) begin
      step();
      m_ptr = exp_q[k]; lx = m_ptr / 4; ly = m_ptr % 4;
      e = expv(oh(m_ptr), 1'b1, 2 - k, 1'b0, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL basic_grant: got %h expected %h", obs(), e); end
    end
    step();
    e = expv(16'd0, 1'b0, 0, 1'b1, 3, 0); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL basic_release: got %h expected %h", obs(), e); end
    step();
    e = expv(16'd0, 1'b0, 0, 1'b0, 3, 0); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL basic_release_end: got %h expected %h", obs(), e); end
  endtask

  task automatic test_fairness();
    logic [26:0] e;
    do_refresh();
    arb_if.req_i = oh(5);
    step();
    arb_if.req_i = oh(0);   // new request mid-group, snapshotted bit dropped
    step();
    m_ptr = 5; lx = 1; ly = 1;
    e = expv(oh(5), 1'b1, 0, 1'b0, 1, 1); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL fair_grant_5: got %h expected %h", obs(), e); end
    step();
    e = expv(16'd0, 1'b0, 0, 1'b1, 1, 1); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL fair_release: got %h expected %h", obs(), e); end
    step();
    arb_if.req_i = '0;
    e = expv(16'd0, 1'b0, 1, 1'b0, 1, 1); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL fair_resnapshot: got %h expected %h", obs(), e); end
    step();
    m_ptr = 0; lx = 0; ly = 0;
    e = expv(oh(0), 1'b1, 0, 1'b0, 0, 0); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL fair_grant_0: got %h expected %h", obs(), e); end
    step(); step();
  endtask

  task automatic test_round_robin();
    logic [26:0] e;
    logic [15:0] bits;
    do_refresh();
    arb_if.req_i = 16'hFFFF;
    for (int g = 0; g < 2; g++) begin
      step();
      if (g == 1) arb_if.req_i = '0;
      e = expv(16'd0, 1'b0, 16, 1'b0, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rr_full_snapshot: got %h expected %h", obs(), e); end
      build_order(16'hFFFF);
      for (int k = 0; k < 16; k++) begin
        step();
        m_ptr = exp_q[k]; lx = m_ptr / 4; ly = m_ptr % 4;
        e = expv(oh(m_ptr), 1'b1, 15 - k, 1'b0, lx, ly); n_cmp++;
        if (obs() !== e) begin n_err++; $display("FAIL rr_full_grant: got %h expected %h", obs(), e); end
      end
      step();
      e = expv(16'd0, 1'b0, 0, 1'b1, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rr_full_release: got %h expected %h", obs(), e); end
    end
    step();
    arb_if.req_i = oh(5);
    step(); arb_if.req_i = '0;
    step(); step(); step();
    m_ptr = 5; lx = 1; ly = 1;
    bits = oh(2) | oh(9);
    arb_if.req_i = bits;
    step(); arb_if.req_i = '0;
    build_order(bits);
    for (int k = 0; k < exp_q.size(); k++) begin
      step();
      m_ptr = exp_q[k]; lx = m_ptr / 4; ly = m_ptr % 4;
      e = expv(oh(m_ptr), 1'b1, 1 - k, 1'b0, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rr_ptr5_grant: got %h expected %h", obs(), e); end
    end
    step(); step();
  endtask

  task automatic test_enable_drop();
    logic [26:0] e;
    logic [15:0] bits;
    do_refresh();
    bits = 16'h1249;
    arb_if.req_i = bits;
    build_order(bits);
    step();
    for (int k = 0; k < 2; k++) begin
      step();
      m_ptr = exp_q[k]; lx = m_ptr / 4; ly = m_ptr % 4;
      e = expv(oh(m_ptr), 1'b1, 4 - k, 1'b0, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL en_pre_grant: got %h expected %h", obs(), e); end
    end
    arb_if.enable_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      e = expv(16'd0, 1'b0, 0, 1'b0, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL en_dropped: got %h expected %h", obs(), e); end
    end
    arb_if.enable_i = 1'b1;
    step(); arb_if.req_i = '0;
    e = expv(16'd0, 1'b0, 5, 1'b0, lx, ly); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL en_resnapshot: got %h expected %h", obs(), e); end
    build_order(bits);
    for (int k = 0; k < 5; k++) begin
      step();
      m_ptr = exp_q[k]; lx = m_ptr / 4; ly = m_ptr % 4;
      e = expv(oh(m_ptr), 1'b1, 4 - k, 1'b0, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL en_regrant: got %h expected %h", obs(), e); end
    end
    step(); step();
  endtask

  task automatic test_refresh();
    logic [26:0] e;
    logic [15:0] bits;
    do_refresh();
    arb_if.req_i = oh(5);
    step(); arb_if.req_i = '0;
    step(); step(); step();
    m_ptr = 5; lx = 1; ly = 1;
    bits = oh(2) | oh(7) | oh(10);
    arb_if.req_i = bits;
    step(); arb_if.req_i = '0;
    arb_if.refresh_i = 1'b1;
    step();
    arb_if.refresh_i = 1'b0;
    lx = 1; ly = 3;
    e = expv(oh(7), 1'b1, 2, 1'b0, lx, ly); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL refresh_grant_7: got %h expected %h", obs(), e); end
    m_ptr = 15;
    build_order(oh(2) | oh(10));
    for (int k = 0; k < exp_q.size(); k++) begin
      step();
      m_ptr = exp_q[k]; lx = m_ptr / 4; ly = m_ptr % 4;
      e = expv(oh(m_ptr), 1'b1, 1 - k, 1'b0, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL refresh_after: got %h expected %h", obs(), e); end
    end
    step(); step();
  endtask

  task automatic test_random_groups();
    logic [26:0] e;
    logic [15:0] bits;
    logic [15:0] nxt;
    logic        rf;
    bits = 16'($urandom) | oh($urandom_range(15, 0));
    arb_if.req_i = bits;
    step();
    for (int g = 0; g < 8; g++) begin
      build_order(bits);
      e = expv(16'd0, 1'b0, exp_q.size(), 1'b0, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rand_snapshot: got %h expected %h", obs(), e); end
      for (int k = 0; k < exp_q.size(); k++) begin
        arb_if.req_i = 16'($urandom);
        step();
        m_ptr = exp_q[k]; lx = m_ptr / 4; ly = m_ptr % 4;
        e = expv(oh(m_ptr), 1'b1, exp_q.size() - 1 - k, 1'b0, lx, ly); n_cmp++;
        if (obs() !== e) begin n_err++; $display("FAIL rand_grant: got %h expected %h", obs(), e); end
      end
      nxt = (g < 7) ? (16'($urandom) | oh($urandom_range(15, 0))) : 16'd0;
      arb_if.req_i = nxt;
      step();
      e = expv(16'd0, 1'b0, 0, 1'b1, lx, ly); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rand_release: got %h expected %h", obs(), e); end
      rf = 1'($urandom_range(1, 0));
      arb_if.refresh_i = rf;
      if (rf) m_ptr = 15;
      step();
      arb_if.refresh_i = 1'b0;
      bits = nxt;
    end
    e = expv(16'd0, 1'b0, 0, 1'b0, lx, ly); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL rand_final_idle: got %h expected %h", obs(), e); end
  endtask

  initial begin
    reset_i          = 1'b1;
    arb_if.enable_i  = 1'b0;
    arb_if.refresh_i = 1'b0;
    arb_if.req_i     = '0;
    test_reset();
    test_basic_group();
    test_fairness();
    test_round_robin();
    test_enable_drop();
    test_refresh();
    test_random_groups();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
